// File: rtl/fetch_controller_if.sv
// fetch_controller_if
// Bundles every signal of fetch_controller except clk/rst.
//   run control    : enable
//   memory port    : mem_address, mem_read, mem_write, mem_wdata, mem_rdata
//   instr handoff  : instr, instr_pc, instr_valid, instr_ready,
//                    branch_valid, branch_target
//   data requests  : dreq, dwe, daddr, dwdata, dack, drdata
//   status         : pc
// The master modport is the controller itself. The slave modport is the
// surrounding memory, execute stage and run control.
interface fetch_controller_if;
  logic       enable;
  logic [3:0] mem_address;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic [7:0] instr;
  logic [3:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic       branch_valid;
  logic [3:0] branch_target;
  logic       dreq;
  logic       dwe;
  logic [3:0] daddr;
  logic [7:0] dwdata;
  logic       dack;
  logic [7:0] drdata;
  logic [3:0] pc;

  modport master (
    input  enable, mem_rdata, instr_ready, branch_valid, branch_target,
           dreq, dwe, daddr, dwdata,
    output mem_address, mem_read, mem_write, mem_wdata,
           instr, instr_pc, instr_valid, dack, drdata, pc
  );

  modport slave (
    output enable, mem_rdata, instr_ready, branch_valid, branch_target,
           dreq, dwe, daddr, dwdata,
    input  mem_address, mem_read, mem_write, mem_wdata,
           instr, instr_pc, instr_valid, dack, drdata, pc
  );
endinterface

// File: rtl/fetch_controller.sv
// fetch_controller
// Sequencer that owns the single port of a 16x8 unified memory. It fetches
// instructions at pc and hands them to the execute stage over a valid/ready
// handshake. It also interleaves execute-stage loads and stores on the same
// port, and a data request wins over the next fetch.
// Ports:
//   clk  - sole clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - fetch_controller_if.master (memory pins, instruction handoff,
//          data request channel, run control, pc)
// Parameter:
//   RESET_PC - program counter value after reset
module fetch_controller #(
  parameter logic [3:0] RESET_PC = 4'd0
) (
  input logic               clk,
  input logic               rst,
  fetch_controller_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DATA  = 2'd3
  } state_t;

  state_t     state_r;
  state_t     state_next_s;

  logic [3:0] pc_r;
  logic [7:0] instr_r;
  logic [3:0] instr_pc_r;
  logic       instr_valid_r;
  logic       dack_r;
  logic [7:0] drdata_r;

  logic [3:0] mem_address_s;
  logic       mem_read_s;
  logic       mem_write_s;
  logic [7:0] mem_wdata_s;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; data requests take precedence over fetching
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        // While dack is high the requester is still dropping dreq, so a
        // lingering dreq must not start a second access.
        if (bus.dreq && !dack_r) begin
          state_next_s = DATA;
        end else if (bus.enable) begin
          state_next_s = FETCH;
        end else begin
          state_next_s = IDLE;
        end
      end
      FETCH: begin
        state_next_s = HOLD;
      end
      HOLD: begin
        if (!bus.instr_ready) begin
          state_next_s = HOLD;
        end else if (bus.dreq) begin
          state_next_s = DATA;
        end else if (bus.enable) begin
          state_next_s = FETCH;
        end else begin
          state_next_s = IDLE;
        end
      end
      DATA: begin
        if (bus.enable) begin
          state_next_s = FETCH;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Memory pin decode from the registered state. Reset forces IDLE at once,
  // so mem_write falls without waiting for a clock edge.
  always_comb begin
    mem_address_s = 4'd0;
    mem_read_s    = 1'b0;
    mem_write_s   = 1'b0;
    mem_wdata_s   = 8'd0;
    case (state_r)
      FETCH: begin
        mem_address_s = pc_r;
        mem_read_s    = 1'b1;
      end
      DATA: begin
        mem_address_s = bus.daddr;
        mem_wdata_s   = bus.dwdata;
        mem_read_s    = ~bus.dwe;
        mem_write_s   = bus.dwe;
      end
      default: begin
        mem_address_s = 4'd0;
      end
    endcase
  end

  // Datapath registers: pc, instruction handoff and data completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r          <= RESET_PC;
      instr_r       <= 8'd0;
      instr_pc_r    <= 4'd0;
      instr_valid_r <= 1'b0;
      dack_r        <= 1'b0;
      drdata_r      <= 8'd0;
    end else begin
      dack_r <= (state_r == DATA);
      case (state_r)
        FETCH: begin
          instr_r       <= bus.mem_rdata;
          instr_pc_r    <= pc_r;
          pc_r          <= pc_r + 4'd1;
          instr_valid_r <= 1'b1;
        end
        HOLD: begin
          // A branch is honoured only together with the accept
          if (bus.instr_ready) begin
            instr_valid_r <= 1'b0;
            if (bus.branch_valid) begin
              pc_r <= bus.branch_target;
            end else begin
              pc_r <= pc_r;
            end
          end else begin
            instr_valid_r <= 1'b1;
          end
        end
        DATA: begin
          if (!bus.dwe) begin
            drdata_r <= bus.mem_rdata;
          end else begin
            drdata_r <= drdata_r;
          end
        end
        default: begin
          pc_r <= pc_r;
        end
      endcase
    end
  end

  assign bus.mem_address = mem_address_s;
  assign bus.mem_read    = mem_read_s;
  assign bus.mem_write   = mem_write_s;
  assign bus.mem_wdata   = mem_wdata_s;
  assign bus.instr       = instr_r;
  assign bus.instr_pc    = instr_pc_r;
  assign bus.instr_valid = instr_valid_r;
  assign bus.dack        = dack_r;
  assign bus.drdata      = drdata_r;
  assign bus.pc          = pc_r;

endmodule
